// File: rtl/pps_store_queue_pkg.sv
// Shared definitions for the PPS store-alignment / store-buffer stage:
// memory-op type codes, address width and the byte-lane width helper.
package pps_store_queue_pkg;

  localparam int ADDR_W   = 32;
  localparam int MEM_OP_W = 7;

  localparam logic [MEM_OP_W-1:0] tMEM_OP_NULL  = 7'h00;
  localparam logic [MEM_OP_W-1:0] tMEM_OP_BYTE  = 7'h01;
  localparam logic [MEM_OP_W-1:0] tMEM_OP_HWORD = 7'h02;
  localparam logic [MEM_OP_W-1:0] tMEM_OP_WORD  = 7'h04;
  localparam logic [MEM_OP_W-1:0] tMEM_OP_DWORD = 7'h08;

  // Number of address bits selecting a byte lane within one bus word.
  function automatic int lane_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/pps_store_queue_st_align.sv
// Combinational store aligner: turns (type, lane, LSB-justified data) into
// byte enables and lane-shifted write data, and classifies the access.
module pps_st_align
  import pps_store_queue_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int MEM_OP_TYPE_SIZE = 7
) (
  input  logic [MEM_OP_TYPE_SIZE-1:0]   memop_type,
  input  logic [lane_w(DATA_W)-1:0]     lane,
  input  logic [DATA_W-1:0]             data,
  output logic [DATA_W/8-1:0]           bwe,
  output logic [DATA_W-1:0]             wdata,
  output logic                          misalign,
  output logic                          legal
);

  localparam int BYTES = DATA_W / 8;

  always_comb begin
    bwe      = '0;
    misalign = 1'b0;
    legal    = 1'b1;
    // Data is always shifted by the lane; bytes outside bwe are don't-care.
    wdata    = data << {lane, 3'b000};
    case (memop_type)
      MEM_OP_TYPE_SIZE'(tMEM_OP_BYTE): begin
        bwe = BYTES'(1) << lane;
      end
      MEM_OP_TYPE_SIZE'(tMEM_OP_HWORD): begin
        bwe      = BYTES'(2'b11) << lane;
        misalign = lane[0];
      end
      MEM_OP_TYPE_SIZE'(tMEM_OP_WORD): begin
        bwe      = BYTES'(4'hF) << lane;
        misalign = |lane[1:0];
      end
      MEM_OP_TYPE_SIZE'(tMEM_OP_DWORD): begin
        bwe      = '1;
        misalign = (DATA_W != 64) || (lane != '0);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pps_store_queue.sv
// Store buffer between PPS Execute and data memory: aligns stores, holds them
// in a DEPTH-entry FIFO, drains over req/ack and flags load-after-store hazards.
module pps_store_queue
  import pps_store_queue_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int DEPTH            = 4,
  parameter int MEM_OP_TYPE_SIZE = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_st_valid,
  output logic                          ex_st_ready,
  input  logic [ADDR_W-1:0]             ex_addr,
  input  logic [DATA_W-1:0]             ex_data,
  input  logic [MEM_OP_TYPE_SIZE-1:0]   ex_memop_type,
  output logic                          ex_misalign,
  input  logic                          ld_valid,
  input  logic [ADDR_W-1:0]             ld_addr,
  output logic                          ld_hazard,
  output logic                          mem_req,
  input  logic                          mem_ack,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_bwe,
  output logic [$clog2(DEPTH):0]        sq_count
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = lane_w(DATA_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BYTES-1:0]  bwe;
  } entry_t;

  entry_t             entry_q [DEPTH];
  logic [DEPTH-1:0]   entry_vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [BYTES-1:0]   al_bwe;
  logic [DATA_W-1:0]  al_wdata;
  logic               al_misalign;
  logic               al_legal;
  logic               enq;
  logic               deq;
  logic               hit;
  logic               unused_ld_lane;
  entry_t             head;

  pps_st_align #(
    .DATA_W           (DATA_W),
    .MEM_OP_TYPE_SIZE (MEM_OP_TYPE_SIZE)
  ) u_align (
    .memop_type (ex_memop_type),
    .lane       (ex_addr[LANE_W-1:0]),
    .data       (ex_data),
    .bwe        (al_bwe),
    .wdata      (al_wdata),
    .misalign   (al_misalign),
    .legal      (al_legal)
  );

  // Ready depends only on occupancy, so a slot freed this edge shows next cycle.
  assign ex_st_ready = (count != CNT_W'(DEPTH));
  assign ex_misalign = ex_st_valid & al_legal & al_misalign;
  assign enq         = ex_st_valid & ex_st_ready & al_legal & ~al_misalign;
  assign mem_req     = (count != '0);
  assign deq         = mem_req & mem_ack;
  assign sq_count    = count;

  assign head      = entry_q[rd_ptr];
  assign mem_addr  = mem_req ? head.addr  : '0;
  assign mem_wdata = mem_req ? head.wdata : '0;
  assign mem_bwe   = mem_req ? head.bwe   : '0;

  // Hazard compares bus-word addresses only; the byte offset of the load is irrelevant.
  assign unused_ld_lane = ^ld_addr[LANE_W-1:0];

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_q[i].addr[ADDR_W-1:LANE_W] == ld_addr[ADDR_W-1:LANE_W])) begin
        hit = 1'b1;
      end
    end
    ld_hazard = ld_valid & hit;
  end

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (deq) begin
        entry_vld[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (enq) begin
        entry_vld[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Entry payload is qualified by entry_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_q[wr_ptr] <= '{addr:  {ex_addr[ADDR_W-1:LANE_W], LANE_W'(0)},
                           wdata: al_wdata,
                           bwe:   al_bwe};
    end
  end

endmodule

// File: tb/tb_pps_store_queue.sv
// Scoreboard bench for pps_store_queue: directed corner cases plus randomized
// traffic on a 32-bit instance, and directed checks on a 64-bit instance.
module tb_pps_store_queue;
  import pps_store_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        st_valid, ld_valid, mem_ack;
  logic [31:0] addr, data, ld_addr;
  logic [6:0]  mtype;
  logic        st_ready, misalign, ld_hazard, mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bwe;
  logic [2:0]  sq_count;

  // 64-bit instance
  logic        v64, ack64, ldv64;
  logic [31:0] a64, lda64;
  logic [63:0] d64;
  logic [6:0]  t64;
  logic        rdy64, mis64, haz64, req64;
  logic [31:0] maddr64;
  logic [63:0] mwdata64;
  logic [7:0]  mbwe64;
  logic [2:0]  cnt64;

  pps_store_queue #(.DATA_W(32), .DEPTH(DEPTH), .MEM_OP_TYPE_SIZE(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_st_valid(st_valid), .ex_st_ready(st_ready), .ex_addr(addr), .ex_data(data),
    .ex_memop_type(mtype), .ex_misalign(misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bwe(mem_bwe), .sq_count(sq_count)
  );

  pps_store_queue #(.DATA_W(64), .DEPTH(DEPTH), .MEM_OP_TYPE_SIZE(7)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .ex_st_valid(v64), .ex_st_ready(rdy64), .ex_addr(a64), .ex_data(d64),
    .ex_memop_type(t64), .ex_misalign(mis64),
    .ld_valid(ldv64), .ld_addr(lda64), .ld_hazard(haz64),
    .mem_req(req64), .mem_ack(ack64), .mem_addr(maddr64), .mem_wdata(mwdata64),
    .mem_bwe(mbwe64), .sq_count(cnt64)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bwe;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  int          m_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference alignment from access size and address arithmetic.
  function automatic void ref_align(input logic [6:0] t, input logic [31:0] a,
                                    input logic [63:0] d, input int nbytes,
                                    output bit legal, output bit mis,
                                    output logic [63:0] bwe, output logic [63:0] wd);
    int sz;
    int lane;
    lane = int'(a % nbytes);
    case (t)
      tMEM_OP_BYTE:  sz = 1;
      tMEM_OP_HWORD: sz = 2;
      tMEM_OP_WORD:  sz = 4;
      tMEM_OP_DWORD: sz = 8;
      default:       sz = 0;
    endcase
    legal = (sz != 0);
    mis = 1'b0;
    if (legal) mis = (sz > nbytes) || ((a % sz) != 0);
    bwe = (((64'd1 << sz) - 64'd1) << lane) & ((64'd1 << nbytes) - 64'd1);
    wd  = d << (8 * lane);
    if (nbytes == 4) wd = wd & 64'hFFFF_FFFF;
  endfunction

  // One cycle on the 32-bit instance; entered and left at posedge+1.
  task automatic step(input bit v, input logic [6:0] t, input logic [31:0] a,
                      input logic [31:0] d, input bit ack, input bit lv,
                      input logic [31:0] la);
    bit          legal, mis, enq, deq, haz;
    logic [63:0] bwe, wd;
    exp_t        e;
    st_valid = v; mtype = t; addr = a; data = d;
    mem_ack = ack; ld_valid = lv; ld_addr = la;
    ref_align(t, a, {32'b0, d}, 4, legal, mis, bwe, wd);
    haz = 1'b0;
    foreach (pend_q[i]) if ((pend_q[i] >> 2) == (la >> 2)) haz = 1'b1;
    #1;
    chk("ready",     st_ready,  m_cnt < DEPTH);
    chk("misalign",  misalign,  v && legal && mis);
    chk("ld_hazard", ld_hazard, lv && haz);
    chk("mem_req",   mem_req,   m_cnt > 0);
    chk("sq_count",  sq_count,  m_cnt);
    enq = v && (m_cnt < DEPTH) && legal && !mis;
    deq = ack && (m_cnt > 0);
    if (enq) begin
      e.addr  = a & ~32'h3;
      e.wdata = wd[31:0];
      e.bwe   = bwe[3:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (deq) void'(pend_q.pop_front());
    if (enq) pend_q.push_back(a & ~32'h3);
    m_cnt = m_cnt + int'(enq) - int'(deq);
  endtask

  task automatic idle(input bit ack);
    step(1'b0, tMEM_OP_NULL, 32'h0, 32'h0, ack, 1'b0, 32'h0);
  endtask

  // Monitor: every accepted memory write must match the next expected store.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drain_unexpected: got write to 0x%0h expected none", mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr",  mem_addr,  e.addr);
          chk("drain_wdata", mem_wdata, e.wdata);
          chk("drain_bwe",   mem_bwe,   e.bwe);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [6:0] types [6];

  initial begin
    types[0] = tMEM_OP_NULL;  types[1] = tMEM_OP_BYTE; types[2] = tMEM_OP_HWORD;
    types[3] = tMEM_OP_WORD;  types[4] = tMEM_OP_DWORD; types[5] = 7'h55;
    st_valid = 0; ld_valid = 0; mem_ack = 0; addr = 0; data = 0; ld_addr = 0;
    mtype = tMEM_OP_NULL;
    v64 = 0; ack64 = 0; ldv64 = 0; a64 = 0; lda64 = 0; d64 = 0; t64 = tMEM_OP_NULL;

    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_count",   sq_count, 0);
    chk("rst_ready",   st_ready, 1);
    chk("rst_addr",    mem_addr, 0);
    chk("rst_wdata",   mem_wdata, 0);
    chk("rst_bwe",     mem_bwe, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store into the top lane
    step(1, tMEM_OP_BYTE, 32'h1003, 32'h0000_00AB, 0, 0, 0);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_bwe",  mem_bwe, 4'b1000);
    chk("sb_byte", mem_wdata[31:24], 8'hAB);
    idle(1);

    // Misaligned halfword dropped, aligned word queued
    step(1, tMEM_OP_HWORD, 32'h2001, 32'h0000_1234, 0, 0, 0);
    chk("sh_count", sq_count, 0);
    step(1, tMEM_OP_WORD, 32'h2004, 32'hCAFE_F00D, 0, 0, 0);
    chk("sw_bwe", mem_bwe, 4'hF);
    idle(1);

    // Fill, backpressure, release one slot, refill, drain in order
    for (int i = 0; i < 5; i++)
      step(1, tMEM_OP_WORD, 32'h5000 + 32'(4 * i), $urandom, 0, 0, 0);
    chk("full_ready", st_ready, 0);
    step(1, tMEM_OP_WORD, 32'h5010, 32'h5555_0005, 1, 0, 0);
    chk("freed_ready", st_ready, 1);
    step(1, tMEM_OP_WORD, 32'h5010, 32'h5555_0005, 0, 0, 0);
    chk("refill_count", sq_count, 4);
    for (int i = 0; i < 4; i++) idle(1);

    // Load-after-store hazard
    step(1, tMEM_OP_WORD, 32'h3008, 32'h1111_2222, 0, 0, 0);
    st_valid = 0; ld_valid = 1; ld_addr = 32'h300A; #1;
    chk("haz_same_word", ld_hazard, 1);
    ld_addr = 32'h300C; #1;
    chk("haz_next_word", ld_hazard, 0);
    ld_addr = 32'h3008; mem_ack = 1; #1;
    chk("haz_while_ack", ld_hazard, 1);
    step(0, tMEM_OP_NULL, 0, 0, 1, 1, 32'h3008);
    chk("haz_after_ack", ld_hazard, 0);
    idle(0);

    // 64-bit instance: doubleword, upper-word store, illegal doubleword
    v64 = 1; t64 = tMEM_OP_DWORD; a64 = 32'h40; d64 = 64'h1122_3344_5566_7788; #1;
    chk("sd64_misalign", mis64, 0);
    @(posedge clk); #1;
    v64 = 0;
    chk("sd64_bwe",   mbwe64, 8'hFF);
    chk("sd64_addr",  maddr64, 32'h40);
    chk("sd64_wdata", mwdata64, 64'h1122_3344_5566_7788);
    v64 = 1; t64 = tMEM_OP_WORD; a64 = 32'h44; d64 = 64'h0000_0000_DEAD_BEEF; ack64 = 1;
    @(posedge clk); #1;
    v64 = 0; ack64 = 0;
    chk("sw64_bwe",   mbwe64, 8'hF0);
    chk("sw64_data",  mwdata64[63:32], 32'hDEAD_BEEF);
    chk("sw64_addr",  maddr64, 32'h40);
    v64 = 1; t64 = tMEM_OP_DWORD; a64 = 32'h44; #1;
    chk("sd64_odd_misalign", mis64, 1);
    v64 = 0;
    @(posedge clk); #1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, types[$urandom_range(0, 5)],
           32'h3000 + 32'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           32'h3000 + 32'($urandom_range(0, 31)));
    end

    // Asynchronous reset with three entries pending
    for (int n = 0; n < 8 && m_cnt > 0; n++) idle(1);
    for (int i = 0; i < 3; i++)
      step(1, tMEM_OP_WORD, 32'h6000 + 32'(4 * i), $urandom, 0, 0, 0);
    chk("pre_reset_count", sq_count, 3);
    st_valid = 0; mem_ack = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_count",   sq_count, 0);
    chk("arst_ready",   st_ready, 1);
    chk("arst_bwe",     mem_bwe, 0);
    exp_q.delete();
    pend_q.delete();
    m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 100; n++) begin
      step($urandom_range(0, 1) == 1, types[$urandom_range(1, 3)],
           32'h7000 + 32'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1) == 1, 1'b1, 32'h7000 + 32'($urandom_range(0, 15)));
    end

    for (int n = 0; n < 20 && m_cnt > 0; n++) idle(1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
